// File: rtl/stopwatch_core.sv
// Stopwatch control FSM with a centisecond timebase and cascaded binary time counters.
// Wraps 23:59:59.99 back to 00:00:00.00.
module stopwatch_core #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic       i_clear,
  output logic       o_running,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned DivW = $clog2(DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);

  typedef enum logic [1:0] {StStop, StRun, StClear} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [6:0]      msec_q, msec_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      min_q, min_d;
  logic [4:0]      hour_q, hour_d;
  logic            running_q;
  logic            tick;

  assign tick = (state_q == StRun) && (div_q == DivMax);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStop: begin
        if (i_clear) begin
          state_d = StClear;
        end else if (i_run) begin
          state_d = StRun;
        end
      end
      StRun:   if (i_run) state_d = StStop;
      StClear: state_d = StStop;
      default: state_d = StStop;
    endcase
  end

  // Divider holds in STOP so a resume keeps the partial tick.
  always_comb begin
    div_d  = div_q;
    msec_d = msec_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (state_q == StClear) begin
      div_d  = '0;
      msec_d = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (state_q == StRun) begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) begin
        if (msec_q == 7'd99) begin
          msec_d = '0;
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
              min_d  = '0;
              hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          msec_d = msec_q + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StStop;
      div_q     <= '0;
      msec_q    <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      msec_q    <= msec_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      running_q <= (state_d == StRun);
    end
  end

  assign o_running = running_q;
  assign o_msec    = msec_q;
  assign o_sec     = sec_q;
  assign o_min     = min_q;
  assign o_hour    = hour_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core (DIV=10); expectations come from a total-centisecond model.
module tb_stopwatch_core;

  logic       clk;
  logic       reset;
  logic       i_run;
  logic       i_clear;
  logic       o_running;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;

  stopwatch_core #(
    .CLK_HZ (1000),
    .TICK_HZ(100)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_run    (i_run),
    .i_clear  (i_clear),
    .o_running(o_running),
    .o_msec   (o_msec),
    .o_sec    (o_sec),
    .o_min    (o_min),
    .o_hour   (o_hour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {running, hour, min, sec, msec}
  logic [24:0] act;
  logic [24:0] exp_v;
  assign act = {o_running, o_hour, o_min, o_sec, o_msec};

  logic [24:0] sb[$];
  int n_err = 0;
  int n_chk = 0;

  // Model: 0=stop 1=run 2=clear; time kept as total centiseconds.
  int m_st  = 0;
  int m_div = 0;
  int m_cs  = 0;
  bit m_run = 1'b0;

  task automatic model_reset();
    m_st  = 0;
    m_div = 0;
    m_cs  = 0;
    m_run = 1'b0;
  endtask

  task automatic model_edge(input logic run, input logic clr);
    case (m_st)
      0: begin
        if (clr) m_st = 2;
        else if (run) m_st = 1;
      end
      1: begin
        if (m_div == 9) begin
          m_div = 0;
          m_cs  = (m_cs + 1) % 8640000;
        end else begin
          m_div++;
        end
        if (run) m_st = 0;
      end
      default: begin
        m_div = 0;
        m_cs  = 0;
        m_st  = 0;
      end
    endcase
    m_run = (m_st == 1);
  endtask

  function automatic logic [24:0] model_vec();
    int ms, s, mi, h;
    ms = m_cs % 100;
    s  = (m_cs / 100) % 60;
    mi = (m_cs / 6000) % 60;
    h  = (m_cs / 360000) % 24;
    return {m_run, 5'(h), 6'(mi), 6'(s), 7'(ms)};
  endfunction

  // One clock: drive pulses, let the edge happen, optionally queue the expected outputs.
  task automatic step(input logic run, input logic clr, input bit chk);
    i_run   = run;
    i_clear = clr;
    @(posedge clk);
    model_edge(run, clr);
    if (chk) sb.push_back(model_vec());
    @(negedge clk);
    i_run   = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    i_run   = 1'b0;
    i_clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    sb.push_back(model_vec());
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL reset_held got=%h exp=%h", act, exp_v);
    end
    reset = 1'b0;
    idle(99);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL reset_idle100 got=%h exp=%h", act, exp_v);
    end
  endtask

  task automatic test_run_tick();
    step(1'b1, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL run_rise got=%h exp=%h", act, exp_v);
    end
    idle(8);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL pre_first_tick got=%h exp=%h", act, exp_v);
    end
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL first_tick got=%h exp=%h", act, exp_v);
    end
    idle(39);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL msec5 got=%h exp=%h", act, exp_v);
    end
  endtask

  task automatic test_carry();
    idle(939);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL msec99 got=%h exp=%h", act, exp_v);
    end
    idle(9);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL sec_carry got=%h exp=%h", act, exp_v);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Preload 23:59:59.99 while stopped; the held flops keep it after release.
    force dut.msec_q = 7'd99;
    force dut.sec_q  = 6'd59;
    force dut.min_q  = 6'd59;
    force dut.hour_q = 5'd23;
    step(1'b0, 1'b0, 1'b0);
    release dut.msec_q;
    release dut.sec_q;
    release dut.min_q;
    release dut.hour_q;
    m_cs = 8639999;
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL preload got=%h exp=%h", act, exp_v);
    end
    step(1'b1, 1'b0, 1'b0);
    idle(9);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL day_wrap got=%h exp=%h", act, exp_v);
    end
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_pause();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(34);
    step(1'b1, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL pause_stop got=%h exp=%h", act, exp_v);
    end
    idle(99);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL pause_frozen got=%h exp=%h", act, exp_v);
    end
    step(1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v || o_msec !== 7'd4) begin
      n_err++; $display("FAIL pause_resume got=%h exp=%h", act, exp_v);
    end
  endtask

  task automatic test_clear();
    step(1'b0, 1'b1, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL clear_in_run got=%h exp=%h", act, exp_v);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL clear_state got=%h exp=%h", act, exp_v);
    end
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL clear_done got=%h exp=%h", act, exp_v);
    end
    // A run pulse landing in CLEAR must be dropped.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL run_in_clear got=%h exp=%h", act, exp_v);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b0, 1'b0);
    idle(25);
    step(1'b1, 1'b1, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL both_in_run got=%h exp=%h", act, exp_v);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL both_in_stop got=%h exp=%h", act, exp_v);
    end
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL stays_stopped got=%h exp=%h", act, exp_v);
    end
  endtask

  task automatic test_tick_stop();
    step(1'b1, 1'b0, 1'b0);
    idle(9);
    step(1'b1, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL tick_with_stop got=%h exp=%h", act, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0);
    idle(3000);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL sec3 got=%h exp=%h", act, exp_v);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    sb.push_back(model_vec());
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL async_reset got=%h exp=%h", act, exp_v);
    end
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    idle(9);
    step(1'b0, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_chk++;
    if (act !== exp_v) begin
      n_err++; $display("FAIL no_partial_tick got=%h exp=%h", act, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_carry();
    test_pause();
    test_clear();
    test_simultaneous();
    test_tick_stop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
